// File: rtl/mc_sequencer.sv
// Run sequencer for a Monte Carlo option pricer: clears the datapath, issues N generator
// steps, tracks accepted samples through the present-value latency, then captures mean/variance.
module mc_sequencer #(
    parameter int CNT_W   = 16,
    parameter int PV_LAT  = 4,
    parameter int ACC_LAT = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    input  logic [CNT_W-1:0]        n_samples,
    input  logic [15:0]             kert_in,
    input  logic [15:0]             se05_in,
    input  logic [15:0]             sqrt_in,
    output logic [15:0]             KerT,
    output logic [15:0]             Se05sigmaT,
    output logic [15:0]             sigmaSqrtT,
    output logic                    dp_clr,
    output logic                    gen_en,
    output logic                    acc_en,
    input  logic signed [15:0]      mean_in,
    input  logic signed [31:0]      var_in,
    output logic signed [15:0]      mean_out,
    output logic signed [31:0]      var_out,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_W-1:0]        issued
);

    localparam int WAIT_W = (ACC_LAT < 1) ? 1 : $clog2(ACC_LAT + 1);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   n_q, n_d;
    logic [15:0]        kert_q, kert_d, se05_q, se05_d, sqrt_q, sqrt_d;
    logic [CNT_W-1:0]   issued_q, issued_d;
    logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [PV_LAT-1:0]  sr_q, sr_d;
    logic               gen_en_q, gen_en_d;
    logic               dp_clr_q, dp_clr_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic signed [15:0] mean_q, mean_d;
    logic signed [31:0] var_q, var_d;

    assign KerT       = kert_q;
    assign Se05sigmaT = se05_q;
    assign sigmaSqrtT = sqrt_q;
    assign dp_clr     = dp_clr_q;
    assign gen_en     = gen_en_q;
    assign acc_en     = sr_q[PV_LAT-1];
    assign mean_out   = mean_q;
    assign var_out    = var_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign issued     = issued_q;

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        kert_d    = kert_q;
        se05_d    = se05_q;
        sqrt_d    = sqrt_q;
        wait_d    = wait_q;
        mean_d    = mean_q;
        var_d     = var_q;
        gen_en_d  = 1'b0;
        dp_clr_d  = 1'b0;
        done_d    = 1'b0;
        issued_d  = gen_en_q ? issued_q + CNT_W'(1) : issued_q;
        acc_cnt_d = acc_en ? acc_cnt_q + CNT_W'(1) : acc_cnt_q;
        // acc_en is gen_en seen through the present-value pipeline latency
        sr_d[0] = gen_en_q;
        for (int i = 1; i < PV_LAT; i++) begin
            sr_d[i] = sr_q[i-1];
        end

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    n_d       = n_samples;
                    kert_d    = kert_in;
                    se05_d    = se05_in;
                    sqrt_d    = sqrt_in;
                    issued_d  = '0;
                    acc_cnt_d = '0;
                    wait_d    = '0;
                    sr_d      = '0;
                    if (n_samples == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d  = S_CLEAR;
                        dp_clr_d = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                state_d  = S_RUN;
                gen_en_d = 1'b1;
            end
            S_RUN: begin
                if (issued_d == n_q) begin
                    state_d = S_DRAIN;
                end else begin
                    gen_en_d = 1'b1;
                end
            end
            S_DRAIN: begin
                // The cycle of the last accepted sample counts as the first settling cycle boundary
                if (acc_cnt_d == n_q) begin
                    if (wait_q == WAIT_W'(ACC_LAT)) begin
                        state_d = S_DONE;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                mean_d  = (n_q == '0) ? '0 : mean_in;
                var_d   = (n_q == '0) ? '0 : var_in;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (abort && state_q != S_IDLE) begin
            state_d  = S_IDLE;
            gen_en_d = 1'b0;
            dp_clr_d = 1'b0;
            done_d   = 1'b0;
            sr_d     = '0;
            mean_d   = mean_q;
            var_d    = var_q;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            n_q       <= '0;
            kert_q    <= '0;
            se05_q    <= '0;
            sqrt_q    <= '0;
            issued_q  <= '0;
            acc_cnt_q <= '0;
            wait_q    <= '0;
            sr_q      <= '0;
            gen_en_q  <= 1'b0;
            dp_clr_q  <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            mean_q    <= '0;
            var_q     <= '0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            kert_q    <= kert_d;
            se05_q    <= se05_d;
            sqrt_q    <= sqrt_d;
            issued_q  <= issued_d;
            acc_cnt_q <= acc_cnt_d;
            wait_q    <= wait_d;
            sr_q      <= sr_d;
            gen_en_q  <= gen_en_d;
            dp_clr_q  <= dp_clr_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            mean_q    <= mean_d;
            var_q     <= var_d;
        end
    end

endmodule
